// File: rtl/fetch_cache_pkg.sv
// Shared types and width helpers for the fetch cache.
package fetch_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MISS_WAIT,
    RESPOND
  } state_t;

  localparam int STAT_BITS = 16;

  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int addr_bits, input int num_lines);
    return addr_bits - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/fetch_cache_array.sv
// Valid/tag/data storage for the fetch cache: combinational read, synchronous
// write, synchronous clear of every valid bit.
module fetch_cache_array
  import fetch_cache_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int NUM_LINES = 16
) (
  input  logic                                       clk,
  input  logic                                       clear,
  input  logic [index_bits(NUM_LINES)-1:0]           rd_index,
  output logic                                       rd_valid,
  output logic [tag_bits(ADDR_BITS, NUM_LINES)-1:0]  rd_tag,
  output logic [DATA_BITS-1:0]                       rd_data,
  input  logic                                       wr_en,
  input  logic [index_bits(NUM_LINES)-1:0]           wr_index,
  input  logic [tag_bits(ADDR_BITS, NUM_LINES)-1:0]  wr_tag,
  input  logic [DATA_BITS-1:0]                       wr_data,
  input  logic                                       wr_valid
);
  localparam int TAG_BITS = tag_bits(ADDR_BITS, NUM_LINES);

  logic [NUM_LINES-1:0] valid_reg;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [DATA_BITS-1:0] data_mem [NUM_LINES];

  // Clear outranks a same-cycle write so a flushed fill never becomes valid.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/fetch_cache.sv
// Direct-mapped single-word-line instruction fetch cache in front of the program-memory controller.
// Define FETCH_CACHE_STATS_EN to build saturating hit/miss counters; otherwise both read as zero.
module fetch_cache
  import fetch_cache_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int NUM_LINES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [ADDR_BITS-1:0]  req_address,
  output logic                  req_ready,
  output logic [DATA_BITS-1:0]  req_data,
  output logic                  mem_read_valid,
  output logic [ADDR_BITS-1:0]  mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [DATA_BITS-1:0]  mem_read_data,
  output logic [STAT_BITS-1:0]  hit_count,
  output logic [STAT_BITS-1:0]  miss_count
);
  localparam int INDEX_BITS = index_bits(NUM_LINES);
  localparam int TAG_BITS   = tag_bits(ADDR_BITS, NUM_LINES);

  state_t                 state_reg, state_next;
  logic                   req_ready_reg, req_ready_next;
  logic [DATA_BITS-1:0]   req_data_reg, req_data_next;
  logic                   mem_read_valid_reg, mem_read_valid_next;
  logic [ADDR_BITS-1:0]   mem_read_address_reg, mem_read_address_next;
  logic                   poison_reg, poison_next;

  logic                   rd_valid;
  logic [TAG_BITS-1:0]    rd_tag;
  logic [DATA_BITS-1:0]   rd_data;
  logic                   wr_en, wr_valid;
  logic                   hit;

  fetch_cache_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk      (clk),
    .clear    (flush | ~reset),
    .rd_index (req_address[INDEX_BITS-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (mem_read_address_reg[INDEX_BITS-1:0]),
    .wr_tag   (mem_read_address_reg[ADDR_BITS-1:INDEX_BITS]),
    .wr_data  (mem_read_data),
    .wr_valid (wr_valid)
  );

  assign hit = rd_valid && (rd_tag == req_address[ADDR_BITS-1:INDEX_BITS]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg            <= IDLE;
      req_ready_reg        <= 1'b0;
      req_data_reg         <= '0;
      mem_read_valid_reg   <= 1'b0;
      mem_read_address_reg <= '0;
      poison_reg           <= 1'b0;
    end else begin
      state_reg            <= state_next;
      req_ready_reg        <= req_ready_next;
      req_data_reg         <= req_data_next;
      mem_read_valid_reg   <= mem_read_valid_next;
      mem_read_address_reg <= mem_read_address_next;
      poison_reg           <= poison_next;
    end
  end

  always_comb begin
    state_next            = state_reg;
    req_ready_next        = req_ready_reg;
    req_data_next         = req_data_reg;
    mem_read_valid_next   = mem_read_valid_reg;
    mem_read_address_next = mem_read_address_reg;
    poison_next           = poison_reg;
    wr_en                 = 1'b0;
    wr_valid              = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            req_data_next  = rd_data;
            req_ready_next = 1'b1;
            state_next     = RESPOND;
          end else if (!mem_read_ready) begin
            // Waiting for ready low keeps a stale ready from ending this miss.
            mem_read_valid_next   = 1'b1;
            mem_read_address_next = req_address;
            state_next            = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_next = 1'b0;
          req_data_next       = mem_read_data;
          req_ready_next      = 1'b1;
          wr_en               = 1'b1;
          wr_valid            = !(poison_reg || flush);
          poison_next         = 1'b0;
          state_next          = RESPOND;
        end else if (flush) begin
          poison_next = 1'b1;
        end
      end
      RESPOND: begin
        if (!req_valid) begin
          req_ready_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready        = req_ready_reg;
  assign req_data         = req_data_reg;
  assign mem_read_valid   = mem_read_valid_reg;
  assign mem_read_address = mem_read_address_reg;

`ifdef FETCH_CACHE_STATS_EN
  logic                 hit_inc, miss_inc;
  logic [STAT_BITS-1:0] hit_count_reg, miss_count_reg;

  assign hit_inc  = (state_reg == IDLE) && req_valid && hit;
  assign miss_inc = (state_reg == IDLE) && req_valid && !hit && !mem_read_ready;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (hit_inc && hit_count_reg != '1)   hit_count_reg  <= hit_count_reg + 1'b1;
      if (miss_inc && miss_count_reg != '1) miss_count_reg <= miss_count_reg + 1'b1;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_fetch_cache.sv
// Directed self-checking bench for fetch_cache with a behavioural controller model.
module tb_fetch_cache;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 16;
  localparam int NUM_LINES = 16;
`ifdef FETCH_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 flush = 1'b0;
  logic                 req_valid = 1'b0;
  logic [ADDR_BITS-1:0] req_address = '0;
  logic                 req_ready;
  logic [DATA_BITS-1:0] req_data;
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready = 1'b0;
  logic [DATA_BITS-1:0] mem_read_data = '0;
  logic [15:0]          hit_count, miss_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  fetch_cache #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .NUM_LINES (NUM_LINES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_address      (req_address),
    .req_ready        (req_ready),
    .req_data         (req_data),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  // Controller model: answers after ctl_latency cycles of valid, optionally lingers ready.
  int             ctl_latency = 3;
  int             ctl_linger = 0;
  logic [15:0]    ctl_data = '0;
  int             wait_cnt = 0;
  int             linger_left = 0;
  int             issue_cnt = 0;
  int             violations = 0;
  logic [7:0]     last_issue_addr = '0;
  logic           prev_mrv = 1'b0;

  always @(negedge clk) begin
    if (mem_read_valid && !prev_mrv) begin
      issue_cnt++;
      last_issue_addr = mem_read_address;
      if (mem_read_ready) violations++;
    end
    prev_mrv = mem_read_valid;
    if (mem_read_ready) begin
      if (!mem_read_valid) begin
        if (linger_left == 0) mem_read_ready = 1'b0;
        else linger_left--;
      end
    end else if (mem_read_valid) begin
      wait_cnt++;
      if (wait_cnt >= ctl_latency) begin
        mem_read_ready = 1'b1;
        mem_read_data  = ctl_data;
        wait_cnt       = 0;
        linger_left    = ctl_linger;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // One fetch transaction; flush pulses on the cycle numbered flush_at (-1 = never).
  task automatic fetch(input logic [7:0] addr, input logic [15:0] mem_word, input int flush_at,
                       output logic [15:0] data, output int cycles, output int issues,
                       output logic dropped_ok);
    int start_issues;
    bit got;
    start_issues = issue_cnt;
    ctl_data     = mem_word;
    got          = 1'b0;
    cycles       = 0;
    req_address  = addr;
    req_valid    = 1'b1;
    flush        = (flush_at == 0);
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      flush = (k == flush_at);
      if (req_ready) begin
        got    = 1'b1;
        cycles = k;
      end
    end
    flush = 1'b0;
    data  = req_data;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_timeout addr=%h: req_ready stayed 0, required 1", addr);
    end
    req_valid = 1'b0;
    @(negedge clk);
    dropped_ok = (req_ready == 1'b0);
    issues     = issue_cnt - start_issues;
    $display("fetch addr=%h data=%h cycles=%0d issues=%0d", addr, data, cycles, issues);
  endtask

  logic [15:0] d;
  int          c, i;
  logic        ok;

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0)   begin n_bad++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
    n_cmp++; if (req_data !== 16'h0)   begin n_bad++; $display("FAIL reset_req_data: got %h, required 0000", req_data); end
    n_cmp++; if (mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mrv: got %b, required 0", mem_read_valid); end
    n_cmp++; if (mem_read_address !== 8'h0) begin n_bad++; $display("FAIL reset_mra: got %h, required 00", mem_read_address); end
    n_cmp++; if (hit_count !== 16'h0)  begin n_bad++; $display("FAIL reset_hits: got %h, required 0000", hit_count); end
    n_cmp++; if (miss_count !== 16'h0) begin n_bad++; $display("FAIL reset_misses: got %h, required 0000", miss_count); end
  endtask

  task automatic check_counts(input string tag);
    logic [15:0] eh, em;
    eh = STATS ? 16'(exp_hits) : 16'h0;
    em = STATS ? 16'(exp_misses) : 16'h0;
    n_cmp++; if (hit_count !== eh)  begin n_bad++; $display("FAIL %s_hits: got %h, required %h", tag, hit_count, eh); end
    n_cmp++; if (miss_count !== em) begin n_bad++; $display("FAIL %s_misses: got %h, required %h", tag, miss_count, em); end
  endtask

  task automatic test_cold_miss();
    fetch(8'h12, 16'hBEEF, -1, d, c, i, ok);
    exp_misses = 1;
    n_cmp++; if (d !== 16'hBEEF) begin n_bad++; $display("FAIL cold_data: got %h, required beef", d); end
    n_cmp++; if (last_issue_addr !== 8'h12) begin n_bad++; $display("FAIL cold_addr: got %h, required 12", last_issue_addr); end
    n_cmp++; if (i != 1) begin n_bad++; $display("FAIL cold_issues: got %0d, required 1", i); end
    n_cmp++; if (c != 4) begin n_bad++; $display("FAIL cold_latency: got %0d, required 4", c); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL cold_drop: req_ready not released"); end
    check_counts("cold");
  endtask

  task automatic test_hit();
    fetch(8'h12, 16'hDEAD, -1, d, c, i, ok);
    exp_hits = 1;
    n_cmp++; if (d !== 16'hBEEF) begin n_bad++; $display("FAIL hit_data: got %h, required beef", d); end
    n_cmp++; if (c != 1) begin n_bad++; $display("FAIL hit_latency: got %0d, required 1", c); end
    n_cmp++; if (i != 0) begin n_bad++; $display("FAIL hit_issues: got %0d, required 0", i); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL hit_drop: req_ready not released"); end
    check_counts("hit");
  endtask

  task automatic test_conflict();
    logic [7:0]  addrs [3] = '{8'h22, 8'h12, 8'h22};
    logic [15:0] words [3] = '{16'h1234, 16'hBEEF, 16'h5678};
    for (int k = 0; k < 3; k++) begin
      fetch(addrs[k], words[k], -1, d, c, i, ok);
      exp_misses++;
      n_cmp++; if (d !== words[k]) begin n_bad++; $display("FAIL conflict_data[%0d]: got %h, required %h", k, d, words[k]); end
      n_cmp++; if (i != 1) begin n_bad++; $display("FAIL conflict_issues[%0d]: got %0d, required 1", k, i); end
    end
    check_counts("conflict");
  endtask

  task automatic test_flush_miss();
    fetch(8'h05, 16'h00AA, 2, d, c, i, ok);
    exp_hits = 0; exp_misses = 0;
    n_cmp++; if (d !== 16'h00AA) begin n_bad++; $display("FAIL flushmiss_data: got %h, required 00aa", d); end
    fetch(8'h05, 16'h00AB, -1, d, c, i, ok);
    exp_misses++;
    n_cmp++; if (i != 1) begin n_bad++; $display("FAIL flushmiss_refetch_issues: got %0d, required 1", i); end
    n_cmp++; if (d !== 16'h00AB) begin n_bad++; $display("FAIL flushmiss_refetch_data: got %h, required 00ab", d); end
    fetch(8'h12, 16'hBEEF, -1, d, c, i, ok);
    exp_misses++;
    n_cmp++; if (i != 1) begin n_bad++; $display("FAIL flushmiss_other_line_issues: got %0d, required 1", i); end
    check_counts("flushmiss");
  endtask

  task automatic test_flush_fill_edge();
    fetch(8'h06, 16'h0066, 3, d, c, i, ok);
    exp_hits = 0; exp_misses = 0;
    n_cmp++; if (d !== 16'h0066) begin n_bad++; $display("FAIL fillflush_data: got %h, required 0066", d); end
    fetch(8'h06, 16'h0067, -1, d, c, i, ok);
    exp_misses++;
    n_cmp++; if (i != 1) begin n_bad++; $display("FAIL fillflush_refetch_issues: got %0d, required 1", i); end
    n_cmp++; if (d !== 16'h0067) begin n_bad++; $display("FAIL fillflush_refetch_data: got %h, required 0067", d); end
    check_counts("fillflush");
  endtask

  task automatic test_lingering();
    ctl_linger = 2;
    fetch(8'h40, 16'h4444, -1, d, c, i, ok);
    fetch(8'h41, 16'h4141, -1, d, c, i, ok);
    ctl_linger = 0;
    n_cmp++; if (d !== 16'h4141) begin n_bad++; $display("FAIL linger_data: got %h, required 4141", d); end
    n_cmp++; if (c != 5) begin n_bad++; $display("FAIL linger_latency: got %0d, required 5", c); end
    n_cmp++; if (violations != 0) begin n_bad++; $display("FAIL linger_issue_while_ready: got %0d, required 0", violations); end
  endtask

  task automatic test_flush_hit();
    fetch(8'h41, 16'hAAAA, 0, d, c, i, ok);
    n_cmp++; if (d !== 16'h4141) begin n_bad++; $display("FAIL flushhit_data: got %h, required 4141", d); end
    n_cmp++; if (i != 0) begin n_bad++; $display("FAIL flushhit_issues: got %0d, required 0", i); end
    fetch(8'h41, 16'h4142, -1, d, c, i, ok);
    n_cmp++; if (i != 1) begin n_bad++; $display("FAIL flushhit_refetch_issues: got %0d, required 1", i); end
    n_cmp++; if (d !== 16'h4142) begin n_bad++; $display("FAIL flushhit_refetch_data: got %h, required 4142", d); end
  endtask

  task automatic test_reset_mid_miss();
    ctl_latency = 20;
    req_address = 8'h07;
    req_valid   = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_read_valid !== 1'b1) begin n_bad++; $display("FAIL rstmiss_pending: got %b, required 1", mem_read_valid); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_read_valid !== 1'b0) begin n_bad++; $display("FAIL rstmiss_mrv: got %b, required 0", mem_read_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rstmiss_req_ready: got %b, required 0", req_ready); end
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    ctl_latency = 3;
    exp_hits = 0; exp_misses = 0;
    check_counts("rstmiss_clear");
    fetch(8'h07, 16'h0707, -1, d, c, i, ok);
    exp_misses++;
    n_cmp++; if (i != 1) begin n_bad++; $display("FAIL rstmiss_refetch_issues: got %0d, required 1", i); end
    n_cmp++; if (d !== 16'h0707) begin n_bad++; $display("FAIL rstmiss_refetch_data: got %h, required 0707", d); end
    check_counts("rstmiss");
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_miss();
    test_flush_fill_edge();
    test_lingering();
    test_flush_hit();
    test_reset_mid_miss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_cache.md
# fetch_cache

Direct-mapped, single-word-line read cache between one instruction fetcher and one consumer port of the program-memory controller. Hits return in one cycle without touching the controller. Misses issue a single read through the controller's level-held valid/ready handshake, install the returned word, and relay it to the fetcher. The cache is read-only, since program memory is never written.

## Interface
- ADDR_BITS, 8, address width, matches the controller.
- DATA_BITS, 16, instruction word width.
- NUM_LINES, 16, number of lines; power of two, 2..2^(ADDR_BITS-1).
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-low.
- flush  input  1  single-cycle pulse; invalidates all lines.
- req_valid  input  1  fetcher read request; held high until req_ready is seen.
- req_address  input  ADDR_BITS  fetch address; stable while req_valid is high.
- req_ready  output  1  response valid; held until req_valid drops.
- req_data  output  DATA_BITS  returned word; valid while req_ready is high.
- mem_read_valid  output  1  to the controller consumer read-valid input.
- mem_read_address  output  ADDR_BITS  to the controller consumer read-address input.
- mem_read_ready  input  1  from the controller consumer read-ready output.
- mem_read_data  input  DATA_BITS  from the controller consumer read-data output.
- hit_count  output  16  see Configuration.
- miss_count  output  16  see Configuration.

## Operation
- Address split:
  - index = req_address[log2(NUM_LINES)-1:0]
  - tag = the remaining upper bits, width ADDR_BITS - log2(NUM_LINES)
- Per line: valid bit, tag, data word.
- FSM states are IDLE, MISS_WAIT and RESPOND.
- IDLE, req_valid=1, line valid and tag match (hit):
  - req_data <= line data, req_ready <= 1.
  - Go to RESPOND.
- IDLE, req_valid=1, miss:
  - Issue only when mem_read_ready=0, so a lingering controller ready is never mistaken for a new response.
  - mem_read_valid <= 1, mem_read_address <= req_address.
  - Go to MISS_WAIT.
- MISS_WAIT, mem_read_ready=1:
  - mem_read_valid <= 0.
  - req_data <= mem_read_data, req_ready <= 1.
  - Write data and tag into the line. Set its valid bit unless a flush occurred since the miss was issued.
  - Go to RESPOND.
- RESPOND, req_valid=0: req_ready <= 0, go to IDLE.
- A new request can be sampled on the cycle after returning to IDLE.
- Flush:
  - Clears every valid bit at the edge where it is sampled, in any state.
  - A flush during MISS_WAIT sets a poison flag. The in-flight word is still returned to the fetcher but is not validated. The flag clears when the FSM enters RESPOND.
  - Flush in the same cycle as the fill edge also poisons that fill.
  - Flush in the same cycle as an IDLE hit: the hit uses the pre-flush state and is served.
- Reset mid-miss:
  - mem_read_valid is dropped immediately.
  - The controller then sees valid low and releases the channel itself. No further action is needed.

## Timing
- Reset values:
  - req_ready=0, req_data=0.
  - mem_read_valid=0, mem_read_address=0.
  - hit_count=0, miss_count=0.
  - All valid bits 0, FSM in IDLE, poison flag 0.
- All outputs are registered.
- Hit latency: req_valid sampled at edge N gives req_ready high after edge N.
- Miss: mem_read_valid rises after edge N. mem_read_ready sampled high at edge M gives req_ready high and mem_read_valid low after edge M.
- Minimum miss turnaround is set by controller latency. The cache adds no cycle beyond its registered request and response.
- Handshake is 4-phase on both sides. No output changes while waiting on the other party, except on reset and on flush-driven valid-bit clears.

## Configuration
- FETCH_CACHE_STATS_EN defined:
  - hit_count increments on every IDLE hit.
  - miss_count increments on every miss issue.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset and on flush.
- FETCH_CACHE_STATS_EN undefined: both ports are tied to 0 and no counter logic exists.

## Structure
- Package fetch_cache_pkg holds:
  - State enum (IDLE, MISS_WAIT, RESPOND).
  - Localparam helpers INDEX_BITS = $clog2(NUM_LINES) and TAG_BITS = ADDR_BITS - INDEX_BITS, as functions of the parameters.
- One sub-module, fetch_cache_array: valid/tag/data storage.
  - Combinational read by index.
  - Synchronous write port.
  - Synchronous clear-all input, driven by flush or reset.

## Test plan
- Cold miss:
  - Stimulus: after reset, req 0x12; controller returns 0xBEEF after 3 cycles.
  - Required: mem_read_address=0x12, req_data=0xBEEF, miss_count=1.
- Re-fetch hit:
  - Stimulus: request 0x12 again.
  - Required: req_ready one cycle after request, no mem_read_valid pulse, req_data=0xBEEF, hit_count=1.
- Conflict eviction (NUM_LINES=16):
  - Stimulus: fetch 0x12 (returns 0xBEEF), then 0x22 (returns 0x1234), then 0x12.
  - Required: three misses, and the third returns whatever memory supplies, e.g. 0xBEEF again.
- Flush during miss:
  - Stimulus: pulse flush while in MISS_WAIT for 0x05, which returns 0x00AA; then refetch 0x05.
  - Required: 0x00AA delivered, but the refetch of 0x05 misses.
- Lingering ready:
  - Stimulus: hold mem_read_ready high 2 extra cycles after a fill while a new miss is pending.
  - Required: mem_read_valid stays low until mem_read_ready=0.
- Reset mid-miss:
  - Stimulus: drive reset=0 in MISS_WAIT.
  - Required: next cycle mem_read_valid=0, req_ready=0, and a later fetch of the same address misses.
